// File: rtl/board_pkg.sv
// Shared definitions for the tic-tac-toe board scanner: cell/winner codes,
// FSM states, board geometry and the winning-line index table.
package board_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'b00,
    CELL_X       = 2'b01,
    CELL_O       = 2'b10,
    CELL_INVALID = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10
  } winner_t;

  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } line_t;

  // Rows, then columns, then the two diagonals; order sets win priority.
  function automatic line_t line_cells(input logic [2:0] l);
    line_t t;
    case (l)
      3'd0:    t = '{4'd0, 4'd1, 4'd2};
      3'd1:    t = '{4'd3, 4'd4, 4'd5};
      3'd2:    t = '{4'd6, 4'd7, 4'd8};
      3'd3:    t = '{4'd0, 4'd3, 4'd6};
      3'd4:    t = '{4'd1, 4'd4, 4'd7};
      3'd5:    t = '{4'd2, 4'd5, 4'd8};
      3'd6:    t = '{4'd0, 4'd4, 4'd8};
      default: t = '{4'd2, 4'd4, 4'd6};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/board_scanner_if.sv
// Scan request, grid read port and result signals of the board scanner.
interface board_scanner_if;
  logic       start;
  logic [3:0] rd_sel;
  logic [1:0] rd_value;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       draw;
  logic [2:0] win_line;

  modport master (
    output start, rd_value,
    input  rd_sel, busy, done, winner, draw, win_line
  );

  modport slave (
    input  start, rd_value,
    output rd_sel, busy, done, winner, draw, win_line
  );
endinterface

// File: rtl/board_line_check.sv
// Combinational check of one winning line: three equal X or O cells.
module board_line_check
  import board_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       match,
  output logic [1:0] owner
);
  // INVALID never matches, so it behaves exactly like EMPTY here.
  always_comb begin
    match = (a == b) && (b == c) && ((a == CELL_X) || (a == CELL_O));
    owner = match ? a : '0;
  end
endmodule

// File: rtl/board_scanner.sv
// Reads a 3x3 board into a snapshot, then evaluates the eight winning lines
// one per cycle through a single shared line checker.
module board_scanner #(
  parameter int NUM_CELLS = board_pkg::NUM_CELLS,
  parameter int NUM_LINES = board_pkg::NUM_LINES
) (
  input logic            clk,
  input logic            reset,
  board_scanner_if.slave bus
);
  import board_pkg::*;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [1:0] snap_q [NUM_CELLS];
  logic [1:0] winner_q;
  logic       draw_q;
  logic [2:0] win_line_q;

  line_t      line;
  logic       match;
  logic [1:0] owner;
  logic       full;
  logic       read_last, eval_last;

  assign line      = line_cells(cnt_q[2:0]);
  assign read_last = (cnt_q == 4'(NUM_CELLS - 1));
  assign eval_last = (cnt_q == 4'(NUM_LINES - 1));

  board_line_check u_check (
    .a     (snap_q[line.a]),
    .b     (snap_q[line.b]),
    .c     (snap_q[line.c]),
    .match (match),
    .owner (owner)
  );

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (!((snap_q[i] == CELL_X) || (snap_q[i] == CELL_O))) full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    if (read_last) state_d = EVAL;
      EVAL:    if (eval_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      winner_q   <= '0;
      draw_q     <= 1'b0;
      win_line_q <= '0;
      for (int i = 0; i < NUM_CELLS; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.start) begin
            winner_q   <= '0;
            draw_q     <= 1'b0;
            win_line_q <= '0;
          end
        end
        READ: begin
          snap_q[cnt_q] <= bus.rd_value;
          cnt_q         <= read_last ? '0 : cnt_q + 4'd1;
        end
        EVAL: begin
          // First matching line wins; later matches leave the result alone.
          if (match && (winner_q == WIN_NONE)) begin
            winner_q   <= owner;
            win_line_q <= cnt_q[2:0];
          end
          if (eval_last) draw_q <= (winner_q == WIN_NONE) && !match && full;
          cnt_q <= eval_last ? '0 : cnt_q + 4'd1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    bus.rd_sel   = (state_q == READ) ? cnt_q : '0;
    bus.busy     = (state_q == READ) || (state_q == EVAL);
    bus.done     = (state_q == DONE);
    bus.winner   = winner_q;
    bus.draw     = draw_q;
    bus.win_line = win_line_q;
  end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter NUM_CELLS, default 9: board cells read per scan, indices 0..8, row-major.
REQ-002 Parameter NUM_LINES, default 8: winning lines evaluated per scan.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  scan request; sampled only in IDLE.
REQ-006 rd_sel  output  4  cell index driven to the grid storage read port.
REQ-007 rd_value  input  2  cell value for rd_sel, valid in the same cycle: 00 empty, 01 X, 10 O, 11 invalid.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse marking that the result outputs are valid.
REQ-010 winner  output  2  00 none, 01 X, 10 O.
REQ-011 draw  output  1  board full with no winner.
REQ-012 win_line  output  3  winning line index; 0 when winner = 00.

Function
REQ-013 FSM states: IDLE, READ, EVAL, DONE.
- IDLE->READ on start=1.
- READ->EVAL after cell 8 is captured.
- EVAL->DONE after line 7 is evaluated.
- DONE->IDLE unconditionally.
REQ-014 IDLE: rd_sel=0, busy=0, done=0; result outputs hold their last values.
REQ-015 Start acceptance: winner, draw and win_line clear to 0 on the accepting edge.
REQ-016 READ lasts exactly 9 cycles.
- rd_sel steps 0,1,...,8, one index per cycle.
- rd_value is captured into a 9x2-bit snapshot at each edge.
REQ-017 EVAL lasts exactly 8 cycles, one line per cycle, in fixed order:
- L0 (0,1,2), L1 (3,4,5), L2 (6,7,8)
- L3 (0,3,6), L4 (1,4,7), L5 (2,5,8)
- L6 (0,4,8), L7 (2,4,6)
REQ-018 Line match: all three snapshot cells are equal and each is 01 or 10.
REQ-019 Multiple matching lines (including X and O both matching): the lowest-index line is recorded; later matches are ignored.
REQ-020 Cell value 11 is treated as empty for both matching and fullness.
REQ-021 draw=1 only if no line matched and all 9 cells are 01 or 10.
REQ-022 DONE: done=1 for exactly one cycle; winner, draw and win_line are final and held until the next start acceptance.
REQ-023 Fixed latency: done is high in the 18th cycle after the start-accepting edge.
REQ-024 busy=1 during READ and EVAL; busy=0 in DONE.
REQ-025 start while busy or in DONE is ignored; no queuing.
REQ-026 winner=00 implies win_line=000.
REQ-027 The snapshot is immune to grid writes after capture; a cell changed after its read does not affect the current scan.

Reset
REQ-028 reset=1 at a posedge forces IDLE from any state, including mid-READ and mid-EVAL.
REQ-029 Reset values: rd_sel=0, busy=0, done=0, winner=00, draw=0, win_line=0, snapshot all 00.
REQ-030 reset has priority over start in the same cycle.
REQ-031 Reset aborts a scan in progress without producing a done pulse.

Structure
REQ-032 Shared package board_pkg holds:
- cell codes (EMPTY, X, O, INVALID) and winner codes;
- NUM_CELLS, NUM_LINES;
- the 8x3 line-to-cell index table.
REQ-033 One combinational sub-module, board_line_check: three 2-bit cells in, match and owner out.
REQ-034 board_line_check is instantiated once and muxed by the EVAL line counter.

Verification
REQ-035 Row X win: cells 0,1,2=01, rest 00; pulse start -> done exactly 18 cycles later, winner=01, win_line=0, draw=0.
REQ-036 Diagonal O win: cells 2,4,6=10, cells 0,1=01, rest 00 -> winner=10, win_line=7.
REQ-037 Draw: board X O X / X O O / O X X -> winner=00, draw=1, win_line=0.
REQ-038 Invalid board and invalid cells:
- X on L0 and O on L2 -> winner=01, win_line=0.
- Full board of 11 -> winner=00, draw=0.
REQ-039 Reset mid-EVAL (cycle 12 after start) -> next cycle busy=0 and all outputs at reset values; no done pulse follows.
REQ-040 start held high for 30 cycles -> a second scan begins only after DONE returns to IDLE; back-to-back done pulses are 19 cycles apart.
